// File: rtl/dct_quant_if.sv
// Quantized coefficient stream from dct_quant to the entropy coder.
interface dct_quant_if #(
    parameter int SIZE_OUT = 11
);
    logic signed [SIZE_OUT-1:0] q_data;
    logic        [5:0]          q_idx;
    logic                       q_valid;
    logic                       q_last;
    logic                       q_ready;

    modport master (output q_data, q_idx, q_valid, q_last, input q_ready);
    modport slave  (input q_data, q_idx, q_valid, q_last, output q_ready);
endinterface

// File: rtl/dct_quant.sv
// Captures an 8x8 DCT block, quantizes each coefficient by a reciprocal table and
// streams the results in JPEG zigzag order over a valid/ready handshake.
module dct_quant #(
    parameter int SIZE_IN    = 11,
    parameter int SIZE_RECIP = 16,
    parameter int SIZE_OUT   = 11
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [7:0][7:0][SIZE_IN-1:0]        data_in,
    input  logic                                dct_done,
    input  logic [7:0][7:0][SIZE_RECIP-1:0]     q_recip,
    dct_quant_if.master                         q_out,
    output logic                                busy,
    output logic                                overrun
);
    localparam int MAG_W = SIZE_IN + SIZE_RECIP + 1;
    localparam int Q_W   = MAG_W - 16;

    localparam logic signed [Q_W:0] OUT_MAX = {{(Q_W-SIZE_OUT+2){1'b0}}, {(SIZE_OUT-1){1'b1}}};
    localparam logic signed [Q_W:0] OUT_MIN = {{(Q_W-SIZE_OUT+2){1'b1}}, {(SIZE_OUT-1){1'b0}}};

    // Raster position (row*8+col) of each zigzag index.
    localparam logic [5:0] ZIGZAG [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    // Widen before negating so the most-negative coefficient has a valid magnitude.
    function automatic logic [SIZE_IN-1:0] abs_coef(input logic signed [SIZE_IN-1:0] c);
        logic signed [SIZE_IN:0] w;
        w = {c[SIZE_IN-1], c};
        if (w < 0)
            w = -w;
        return SIZE_IN'(w);
    endfunction

    function automatic logic [Q_W-1:0] round_mag(input logic [SIZE_IN-1:0]    a,
                                                 input logic [SIZE_RECIP-1:0] r);
        logic [MAG_W-1:0] mag;
        mag = MAG_W'(a) * MAG_W'(r) + MAG_W'(32768);
        return Q_W'(mag >> 16);
    endfunction

    function automatic logic signed [SIZE_OUT-1:0] sat_out(input logic neg,
                                                           input logic [Q_W-1:0] q);
        logic signed [Q_W:0] v;
        v = neg ? -$signed({1'b0, q}) : $signed({1'b0, q});
        if (v > OUT_MAX)
            v = OUT_MAX;
        else if (v < OUT_MIN)
            v = OUT_MIN;
        return SIZE_OUT'(v);
    endfunction

    typedef enum logic {IDLE, RUN} state_t;

    state_t                       state, state_nxt;
    logic [6:0]                   k;
    logic [7:0][7:0][SIZE_IN-1:0] blk_p0;
    logic                         capture, load, ovr_nxt, hs;
    logic [5:0]                   pos;
    logic signed [SIZE_IN-1:0]    coef;
    logic [SIZE_RECIP-1:0]        recip;
    logic signed [SIZE_OUT-1:0]   res;

    assign hs = q_out.q_valid && q_out.q_ready;

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        load      = 1'b0;
        ovr_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (dct_done) begin
                    capture   = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                load = (k != 7'd64) && (!q_out.q_valid || hs);
                if (hs && q_out.q_last) begin
                    if (dct_done)
                        capture = 1'b1;
                    else
                        state_nxt = IDLE;
                end else if (dct_done) begin
                    ovr_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: captured block, indexed through the zigzag table by k.
    always_ff @(posedge clk) begin
        if (capture)
            blk_p0 <= data_in;
    end

    assign pos   = ZIGZAG[k[5:0]];
    assign coef  = $signed(blk_p0[pos[5:3]][pos[2:0]]);
    assign recip = q_recip[pos[5:3]][pos[2:0]];
    assign res   = sat_out(coef[SIZE_IN-1], round_mag(abs_coef(coef), recip));

    // Stage p1: registered output word, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            k              <= 7'd0;
            busy           <= 1'b0;
            overrun        <= 1'b0;
            q_out.q_valid  <= 1'b0;
            q_out.q_last   <= 1'b0;
            q_out.q_data   <= '0;
            q_out.q_idx    <= 6'd0;
        end else begin
            state   <= state_nxt;
            busy    <= (state_nxt == RUN);
            overrun <= ovr_nxt;
            if (capture)
                k <= 7'd0;
            else if (load)
                k <= k + 7'd1;
            if (load) begin
                q_out.q_valid <= 1'b1;
                q_out.q_data  <= res;
                q_out.q_idx   <= k[5:0];
                q_out.q_last  <= (k == 7'd63);
            end else if (hs) begin
                q_out.q_valid <= 1'b0;
                q_out.q_last  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dct_quant.sv
// Scoreboard bench for dct_quant: driver pushes expected zigzag streams, monitor pops on handshakes.
module tb_dct_quant;
    localparam int SIZE_IN    = 11;
    localparam int SIZE_RECIP = 16;
    localparam int SIZE_OUT   = 8;
    localparam int OUT_MAX    = (1 << (SIZE_OUT - 1)) - 1;
    localparam int OUT_MIN    = -(1 << (SIZE_OUT - 1));

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [7:0][7:0][SIZE_IN-1:0]    data_in;
    logic                            dct_done;
    logic [7:0][7:0][SIZE_RECIP-1:0] q_recip;
    logic                            busy, overrun;

    dct_quant_if #(.SIZE_OUT(SIZE_OUT)) q_if ();

    dct_quant #(.SIZE_IN(SIZE_IN), .SIZE_RECIP(SIZE_RECIP), .SIZE_OUT(SIZE_OUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .dct_done (dct_done),
        .q_recip  (q_recip),
        .q_out    (q_if),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int data;
        bit last;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   zz_row[64], zz_col[64];
    int   coef[8][8], recip[8][8];
    bit   dd_reject = 1'b0;
    bit   ovr_exp = 1'b0;
    bit   prev_stall = 1'b0;
    int   held_idx, held_data;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Walk the anti-diagonals; odd diagonals run down-left, even ones up-right.
    function automatic void build_zigzag();
        int n = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            for (int i = 0; i <= hi - lo; i++) begin
                int row = (s % 2 == 1) ? lo + i : hi - i;
                zz_row[n] = row;
                zz_col[n] = s - row;
                n++;
            end
        end
    endfunction

    function automatic int quant(input int c, input int r);
        longint mag, q;
        mag = longint'(c < 0 ? -c : c) * longint'(r);
        q   = (mag + 32768) / 65536;
        if (c < 0) q = -q;
        if (q > OUT_MAX) q = OUT_MAX;
        if (q < OUT_MIN) q = OUT_MIN;
        return int'(q);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        dct_done  = 1'b0;
        dd_reject = 1'b0;
    endtask

    // A block is taken only when none is outstanding, or the last entry completes this cycle.
    task automatic try_done();
        bit accept;
        accept = (sbq.size() == 0) || (sbq.size() == 1 && q_if.q_ready);
        if (accept) begin
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++) begin
                    data_in[r][c] = SIZE_IN'(coef[r][c]);
                    q_recip[r][c] = SIZE_RECIP'(recip[r][c]);
                end
            for (int n = 0; n < 64; n++) begin
                exp_t e;
                e.idx  = n;
                e.data = quant(coef[zz_row[n]][zz_col[n]], recip[zz_row[n]][zz_col[n]]);
                e.last = (n == 63);
                sbq.push_back(e);
            end
        end else begin
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    data_in[r][c] = SIZE_IN'($urandom);
            dd_reject = 1'b1;
        end
        dct_done = 1'b1;
    endtask

    task automatic fill_random();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                coef[r][c]  = int'($urandom_range(0, 2047)) - 1024;
                recip[r][c] = int'($urandom_range(0, 65535) >> $urandom_range(0, 10));
            end
    endtask

    task automatic expect_start();
        tick();
        check("busy_after_capture", int'(busy), 1);
        check("valid_at_capture", int'(q_if.q_valid), 0);
        tick();
        check("first_valid", int'(q_if.q_valid), 1);
        check("first_idx", int'(q_if.q_idx), 0);
    endtask

    task automatic drain(input bit rnd);
        int n = 0;
        while (sbq.size() != 0 && n < 400) begin
            tick();
            q_if.q_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            n++;
        end
        if (sbq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d entries left, required 0", sbq.size());
            sbq.delete();
        end
        tick();
        check("busy_end", int'(busy), 0);
        check("valid_end", int'(q_if.q_valid), 0);
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) ovr_exp = 1'b0;
        else      ovr_exp = dct_done && dd_reject;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            check("overrun", int'(overrun), int'(ovr_exp));
            if (prev_stall) begin
                check("hold_valid", int'(q_if.q_valid), 1);
                check("hold_idx", int'(q_if.q_idx), held_idx);
                check("hold_data", int'(q_if.q_data), held_data);
            end
            if (q_if.q_valid && q_if.q_ready) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_output: idx %0d data %0d, required no output",
                             q_if.q_idx, q_if.q_data);
                end else begin
                    e = sbq.pop_front();
                    check("q_idx", int'(q_if.q_idx), e.idx);
                    check("q_data", int'(q_if.q_data), e.data);
                    check("q_last", int'(q_if.q_last), int'(e.last));
                end
            end
            prev_stall = q_if.q_valid && !q_if.q_ready;
            held_idx   = int'(q_if.q_idx);
            held_data  = int'(q_if.q_data);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit pulsed;
        int hold;
        build_zigzag();
        dct_done     = 1'b0;
        data_in      = '0;
        q_recip      = '0;
        q_if.q_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", int'(q_if.q_valid), 0);
        check("rst_last", int'(q_if.q_last), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_data", int'(q_if.q_data), 0);
        check("rst_idx", int'(q_if.q_idx), 0);
        rst = 1'b1;

        // Basic ordering: value equals raster position, reciprocal ~1.0.
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                coef[r][c]  = r * 8 + c;
                recip[r][c] = 65535;
            end
        tick();
        q_if.q_ready = 1'b1;
        try_done();
        expect_start();
        drain(0);

        // Rounding with Q=16 and saturation at 8-bit output.
        for (int pass = 0; pass < 2; pass++) begin
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++) begin
                    int sel = (r * 8 + c) % 4;
                    if (pass == 0) begin
                        coef[r][c]  = (sel == 0) ? 100 : (sel == 1) ? -24 : (sel == 2) ? 8 : -7;
                        recip[r][c] = 4096;
                    end else begin
                        coef[r][c]  = (sel % 2 == 0) ? -1024 : 1023;
                        recip[r][c] = 65535;
                    end
                end
            tick();
            q_if.q_ready = 1'b1;
            try_done();
            expect_start();
            drain(0);
        end

        // Backpressure: stall 5 cycles on idx 10, random ready elsewhere.
        fill_random();
        tick();
        q_if.q_ready = 1'b1;
        try_done();
        pulsed = 1'b0;
        hold   = 0;
        for (int n = 0; n < 400 && sbq.size() != 0; n++) begin
            tick();
            if (hold > 0) begin
                q_if.q_ready = 1'b0;
                hold--;
            end else if (!pulsed && q_if.q_valid && q_if.q_idx == 6'd10) begin
                q_if.q_ready = 1'b0;
                hold   = 4;
                pulsed = 1'b1;
            end else begin
                q_if.q_ready = ($urandom_range(0, 2) != 0);
            end
        end
        drain(1);

        // Overrun at idx 30 of block A, then block B coincident with A's last handshake.
        fill_random();
        tick();
        q_if.q_ready = 1'b1;
        try_done();
        pulsed = 1'b0;
        for (int n = 0; n < 200; n++) begin
            tick();
            if (!pulsed && q_if.q_valid && q_if.q_idx == 6'd30) begin
                try_done();
                pulsed = 1'b1;
            end else if (pulsed && sbq.size() == 1) begin
                fill_random();
                try_done();
                expect_start();
                break;
            end
        end
        check("overrun_pulse_issued", int'(pulsed), 1);
        drain(0);

        // Reset mid-block at idx 40.
        fill_random();
        tick();
        q_if.q_ready = 1'b1;
        try_done();
        pulsed = 1'b0;
        for (int n = 0; n < 200 && !pulsed; n++) begin
            tick();
            if (q_if.q_valid && q_if.q_idx == 6'd40) pulsed = 1'b1;
        end
        check("reached_idx40", int'(pulsed), 1);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_valid", int'(q_if.q_valid), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_last", int'(q_if.q_last), 0);
        check("midrst_idx", int'(q_if.q_idx), 0);
        sbq.delete();
        prev_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        fill_random();
        tick();
        q_if.q_ready = 1'b1;
        try_done();
        expect_start();
        drain(0);

        // Random traffic: random ready, sporadic and back-to-back dct_done.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            tick();
            q_if.q_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 29) == 0 ||
                (sbq.size() == 1 && q_if.q_ready && $urandom_range(0, 1) == 0)) begin
                fill_random();
                try_done();
            end
        end
        drain(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
